// File: rtl/neuron_mac.sv
// Per-neuron multiply-accumulate sequencer: reads weights, accumulates weight*input,
// adds bias, then saturates and presents the result. Optional ReLU on output via `RELU_EN.
module neuron_mac #(
    parameter int numWeights   = 16,
    parameter int addressWidth = 4,
    parameter int dataWidth    = 16,
    parameter int fracBits     = 8,
    parameter int accWidth     = 40
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    output logic                    busy,
    output logic                    weightReadEn,
    output logic [addressWidth-1:0] weightAddr,
    input  logic [dataWidth-1:0]    weightData,
    input  logic [dataWidth-1:0]    bias,
    input  logic                    inValid,
    output logic                    inReady,
    input  logic [dataWidth-1:0]    inData,
    output logic                    outValid,
    input  logic                    outReady,
    output logic [dataWidth-1:0]    outData
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_BIAS  = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    localparam logic [addressWidth-1:0] LAST_IDX = addressWidth'(numWeights - 1);
    localparam logic [addressWidth-1:0] ONE_IDX  = addressWidth'(1);
    localparam logic signed [accWidth-1:0] SAT_MAX =
        {{(accWidth-dataWidth+1){1'b0}}, {(dataWidth-1){1'b1}}};
    localparam logic signed [accWidth-1:0] SAT_MIN =
        {{(accWidth-dataWidth+1){1'b1}}, {(dataWidth-1){1'b0}}};

    state_t                      state_q, state_d;
    logic signed [accWidth-1:0]  acc_q, acc_d;
    logic [addressWidth-1:0]     count_q, count_d;
    logic                        out_valid_q, out_valid_d;
    logic [dataWidth-1:0]        out_data_q, out_data_d;

    logic                        beat_s;
    logic signed [2*dataWidth-1:0] prod_s;
    logic signed [accWidth-1:0]  prod_ext_s;
    logic signed [accWidth-1:0]  bias_ext_s;
    logic signed [accWidth-1:0]  biased_s;
    logic signed [accWidth-1:0]  shifted_s;
    logic [dataWidth-1:0]        sat_s;
    logic [dataWidth-1:0]        result_s;

    // Full-width signed product and bias aligned to the accumulator's binary point
    assign prod_s     = $signed(inData) * $signed(weightData);
    assign prod_ext_s = {{(accWidth-2*dataWidth){prod_s[2*dataWidth-1]}}, prod_s};
    assign bias_ext_s = {{(accWidth-dataWidth-fracBits){bias[dataWidth-1]}}, bias, {fracBits{1'b0}}};
    assign biased_s   = acc_q + bias_ext_s;
    assign shifted_s  = biased_s >>> fracBits;
    assign beat_s     = inValid & inReady;

    // Clamp the rescaled sum into the output range, then optional ReLU
    always_comb begin
        if (shifted_s > SAT_MAX) begin
            sat_s = SAT_MAX[dataWidth-1:0];
        end else if (shifted_s < SAT_MIN) begin
            sat_s = SAT_MIN[dataWidth-1:0];
        end else begin
            sat_s = shifted_s[dataWidth-1:0];
        end
`ifdef RELU_EN
        if (sat_s[dataWidth-1]) begin
            result_s = {dataWidth{1'b0}};
        end else begin
            result_s = sat_s;
        end
`else
        result_s = sat_s;
`endif
    end

    // State and datapath registers, synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            acc_q       <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        count_d     = count_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    acc_d   = '0;
                    count_d = '0;
                    state_d = S_ACCUM;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ACCUM: begin
                if (beat_s) begin
                    acc_d = acc_q + prod_ext_s;
                    // count parks on the last index rather than wrapping
                    if (count_q == LAST_IDX) begin
                        state_d = S_BIAS;
                    end else begin
                        count_d = count_q + ONE_IDX;
                    end
                end else begin
                    state_d = S_ACCUM;
                end
            end
            S_BIAS: begin
                acc_d       = biased_s;
                out_data_d  = result_s;
                out_valid_d = 1'b1;
                state_d     = S_OUT;
            end
            S_OUT: begin
                if (out_valid_q && outReady) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end else begin
                    state_d = S_OUT;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Moore outputs decoded from the current state
    always_comb begin
        busy         = 1'b1;
        weightReadEn = 1'b0;
        weightAddr   = '0;
        inReady      = 1'b0;
        case (state_q)
            S_IDLE: begin
                busy = 1'b0;
            end
            S_ACCUM: begin
                weightReadEn = 1'b1;
                weightAddr   = count_q;
                inReady      = 1'b1;
            end
            S_BIAS, S_OUT: begin
                busy = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    assign outValid = out_valid_q;
    assign outData  = out_data_q;

endmodule

// File: tb/tb_neuron_mac.sv
// Directed self-checking bench for neuron_mac with numWeights=4.
module tb_neuron_mac;

    localparam int NW = 4;
    localparam int AW = 4;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset, start, busy, weightReadEn;
    logic          inValid, inReady, outValid, outReady;
    logic [AW-1:0] weightAddr;
    logic [DW-1:0] weightData, bias, inData, outData;

    logic [DW-1:0] wmem [16];
    logic [DW-1:0] din  [NW];
    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    assign weightData = wmem[weightAddr];

    neuron_mac #(
        .numWeights(NW), .addressWidth(AW), .dataWidth(DW), .fracBits(8), .accWidth(40)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy),
        .weightReadEn(weightReadEn), .weightAddr(weightAddr), .weightData(weightData),
        .bias(bias), .inValid(inValid), .inReady(inReady), .inData(inData),
        .outValid(outValid), .outReady(outReady), .outData(outData)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [DW-1:0] w, input logic [DW-1:0] x);
        for (int i = 0; i < 16; i++) wmem[i] = w;
        for (int i = 0; i < NW; i++) din[i] = x;
    endtask

    task automatic load_mixed();
        for (int i = 0; i < 16; i++) wmem[i] = 16'h0000;
        wmem[0] = 16'h0100; wmem[1] = 16'h0200; wmem[2] = 16'hFF80; wmem[3] = 16'h0040;
        din[0]  = 16'h0100; din[1]  = 16'h0080; din[2]  = 16'h0200; din[3]  = 16'h0400;
    endtask

    // Drives the input stream; pat[i]=1 offers a beat in cycle i, 0 is a gap
    task automatic feed(input string tag, input logic [15:0] pat, input int plen);
        int k = 0;
        for (int i = 0; i < plen; i++) begin
            check($sformatf("%s_addr%0d", tag, i), 32'(weightAddr), 32'(k));
            if (pat[i]) begin
                inValid = 1'b1;
                inData  = din[k];
            end else begin
                inValid = 1'b0;
                inData  = 16'hDEAD;
            end
            tick();
            if (pat[i]) k++;
        end
        inValid = 1'b0;
    endtask

    task automatic run_inf(input string tag, input logic [15:0] pat, input int plen,
                           input logic [DW-1:0] b, input logic [DW-1:0] exp);
        bias  = b;
        start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, "_busy"}, 32'(busy), 32'd1);
        check({tag, "_ren"}, 32'(weightReadEn), 32'd1);
        feed(tag, pat, plen);
        check({tag, "_lat_bias"}, 32'(outValid), 32'd0);
        tick();
        check({tag, "_valid"}, 32'(outValid), 32'd1);
        check({tag, "_data"}, 32'(outData), 32'(exp));
        outReady = 1'b1;
        tick();
        outReady = 1'b0;
        check({tag, "_done_valid"}, 32'(outValid), 32'd0);
        check({tag, "_done_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; inValid = 1'b0; outReady = 1'b0;
        bias = 16'h0000; inData = 16'h0000;
        load(16'h0000, 16'h0000);
        tick();
        tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(outValid), 32'd0);
        check("rst_data", 32'(outData), 32'd0);
        check("rst_ren", 32'(weightReadEn), 32'd0);
        check("rst_inready", 32'(inReady), 32'd0);
        reset = 1'b0;
        tick();

        load(16'h0100, 16'h0200);
        run_inf("basic", 16'h000F, 4, 16'h0080, 16'h0880);

        load(16'h7FFF, 16'h7FFF);
        run_inf("posclamp", 16'h000F, 4, 16'h7FFF, 16'h7FFF);

        load(16'h7FFF, 16'h8000);
`ifdef RELU_EN
        run_inf("negclamp", 16'h000F, 4, 16'h7FFF, 16'h0000);
`else
        run_inf("negclamp", 16'h000F, 4, 16'h7FFF, 16'h8000);
`endif

        load(16'h0100, 16'hFF00);
`ifdef RELU_EN
        run_inf("neg4", 16'h000F, 4, 16'h0000, 16'h0000);
`else
        run_inf("neg4", 16'h000F, 4, 16'h0000, 16'hFC00);
`endif

        // -4 LSB of Q16.16 must floor to -1 LSB, not truncate to zero
        load(16'h0001, 16'hFFFF);
`ifdef RELU_EN
        run_inf("floor", 16'h000F, 4, 16'h0000, 16'h0000);
`else
        run_inf("floor", 16'h000F, 4, 16'h0000, 16'hFFFF);
`endif

        load_mixed();
        run_inf("mixed", 16'h000F, 4, 16'h0040, 16'h0240);
        run_inf("gaps", 16'h0069, 7, 16'h0040, 16'h0240);

        // Back-pressure: result held while outReady is low
        bias  = 16'h0040;
        start = 1'b1;
        tick();
        start = 1'b0;
        feed("hold", 16'h000F, 4);
        tick();
        for (int i = 0; i < 5; i++) begin
            check($sformatf("hold_valid%0d", i), 32'(outValid), 32'd1);
            check($sformatf("hold_data%0d", i), 32'(outData), 32'h0240);
            tick();
        end
        outReady = 1'b1;
        tick();
        outReady = 1'b0;
        check("hold_idle", 32'(busy), 32'd0);
        check("hold_keep_data", 32'(outData), 32'h0240);

        // Abort after two beats, then a clean inference must be unaffected
        load(16'h0100, 16'h0200);
        bias  = 16'h0080;
        start = 1'b1;
        tick();
        start = 1'b0;
        feed("abort", 16'h0003, 2);
        inValid = 1'b1;
        inData  = din[2];
        reset   = 1'b1;
        tick();
        reset   = 1'b0;
        inValid = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_valid", 32'(outValid), 32'd0);
        check("abort_data", 32'(outData), 32'd0);
        check("abort_ren", 32'(weightReadEn), 32'd0);
        check("abort_addr", 32'(weightAddr), 32'd0);
        check("abort_inready", 32'(inReady), 32'd0);
        run_inf("clean", 16'h000F, 4, 16'h0080, 16'h0880);

        // start held high through ACCUM, BIAS, OUT and the handshake edge
        start = 1'b1;
        tick();
        feed("stk", 16'h000F, 4);
        check("stk_bias", 32'(outValid), 32'd0);
        tick();
        check("stk_valid", 32'(outValid), 32'd1);
        check("stk_data", 32'(outData), 32'h0880);
        tick();
        check("stk_out_hold", 32'(outValid), 32'd1);
        outReady = 1'b1;
        tick();
        outReady = 1'b0;
        start    = 1'b0;
        check("stk_idle", 32'(busy), 32'd0);
        tick();
        check("stk_no_restart", 32'(busy), 32'd0);
        check("stk_keep_data", 32'(outData), 32'h0880);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
